weight_fetch_ctrl: RTL and testbench
====================================

# weight_fetch_ctrl

Sequencer for the dual-port weight memory bank feeding the fully-connected layer. Once per inference, on `start`, it sweeps the shared read addresses `addr1`/`addr2` two words per cycle across all weight rows, and tracks memory read latency. It drives the accumulator controls (`acc_clr`, `acc_en`, per-port valid flags, `last`) so that all NC+1 neuron accumulators consume each weight pair exactly once. It sits between the layer top-level FSM and the weight memory bank / MAC array.

## Interface
Parameters:
- `DEPTH`, 784: weight rows per column, addresses 0..DEPTH-1; odd values legal.
- `ADDR_W`, 10: address width; must satisfy 2^ADDR_W >= DEPTH.
- `MEM_LAT`, 1: weight memory read latency in cycles, 1..4.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  one-cycle request; accepted only in IDLE.
- `hold`  in  1  downstream stall; freezes address issue.
- `busy`  out  1  high from the cycle after an accepted `start` through the `done` cycle, inclusive.
- `done`  out  1  one-cycle pulse when the final pair has been consumed.
- `addr1`  out  ADDR_W  port-1 read address (even row).
- `addr2`  out  ADDR_W  port-2 read address (odd row).
- `acc_clr`  out  1  one-cycle accumulator clear, before the first `acc_en`.
- `acc_en`  out  1  weights on the memory outputs are valid this cycle.
- `valid1`  out  1  port-1 data valid (qualifies `acc_en`).
- `valid2`  out  1  port-2 data valid; 0 on the final pair when DEPTH is odd.
- `last`  out  1  coincides with the final `acc_en`.

## Operation
- Pair count P = ceil(DEPTH/2). Pair k issues `addr1`=2k and `addr2`=2k+1.
- When DEPTH is odd, the final pair drives `addr2`=`addr1`, which stays in range, and issues with v2=0.
- States:
  - IDLE: `start` -> CLR.
  - CLR: `acc_clr`=1, k=0 -> RUN.
  - RUN: if !`hold`, issue pair k and increment k. Issuing pair P-1 -> DRAIN.
  - DRAIN: wait until the valid pipe is empty -> DONE.
  - DONE: `done`=1 -> IDLE.
- Issue token {v1,v2,lst} enters a MEM_LAT-deep shift register. Pipe output drives `acc_en`=v1, `valid1`, `valid2`, `last`.
- While `hold`=1:
  - addresses stay frozen and a zero (bubble) token enters the pipe;
  - tokens already in flight still emerge.
- `hold` is ignored outside RUN.
- `start` outside IDLE is ignored; no queueing.
- `start` and `rst` in the same cycle: reset wins.
- `rst` at any time, including mid-sweep, returns to IDLE next edge and flushes the pipe. Reset values:
  - `addr1`=0, `addr2`=0;
  - `busy`, `done`, `acc_clr`, `acc_en`, `valid1`, `valid2`, `last` all 0.
- The pair counter width is ADDR_W; k never wraps because the sweep terminates at P-1.
- In IDLE, addresses hold 0.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- `start` sampled at edge T0: CLR at T1, first issue at T2, first `acc_en` at T2+MEM_LAT.
- No `hold`: issues occupy T2..T1+P, and the final `acc_en` (with `last`) falls at T1+P+MEM_LAT.
- `done` is asserted at T2+P+MEM_LAT.
- Example, DEPTH=784, MEM_LAT=1: P=392; `acc_en` is high T3..T394, `done` at T395.
- Each `hold` cycle in RUN delays `done` by exactly one cycle.
- `acc_clr` always precedes the first `acc_en` by at least MEM_LAT cycles and never overlaps it.
- Back-to-back: `start` sampled in the cycle after `done` (IDLE) is accepted.

## Structure
- Shared package `cnn_pkg`: DEPTH, ADDR_W and NC constants, plus the state enum {IDLE, CLR, RUN, DRAIN, DONE}, reused by the layer top-level FSM.
- One sub-module, `valid_pipe`: parameterised MEM_LAT-deep 3-bit token shift register with synchronous clear. It is reused wherever memory latency must be matched.

## Test plan
- Reset then `start`, DEPTH=784, MEM_LAT=1 -> `acc_clr` at T1; 392 `acc_en` cycles T3..T394; addresses 0/1 up to 782/783; `last`+`acc_en` at T394; `done` at T395.
- DEPTH=7, MEM_LAT=2 -> 4 pairs; final pair `addr1`=`addr2`=6 with `valid2`=0 and `last`=1; `done` 2 cycles after the final issue plus 1.
- `hold` high for 3 cycles mid-RUN, DEPTH=16 -> addresses frozen; exactly 8 `acc_en` pulses with no duplicates; `done` delayed by 3 cycles.
- `start` pulsed during RUN and during DONE -> ignored; only one sweep and one `done`.
- `rst` asserted at pair 100 -> next cycle all outputs 0 and `busy`=0; no `acc_en` afterwards. A subsequent `start` restarts from address 0 with `acc_clr`.
- Back-to-back: `start` in the cycle after `done` -> second sweep timing identical to the first.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared constants and types for the fully-connected layer datapath.
package cnn_pkg;

  localparam int FC_DEPTH  = 784;  // weight rows per column
  localparam int FC_ADDR_W = 10;   // weight memory address width
  localparam int FC_NC     = 9;    // highest neuron index (NC+1 accumulators)

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    RUN,
    DRAIN,
    DONE
  } fsm_state_e;

  // Token travelling alongside a memory read: port validity plus final-pair marker.
  typedef struct packed {
    logic v1;
    logic v2;
    logic lst;
  } tok_t;

  // Two rows are fetched per cycle; an odd row count leaves a half-filled final pair.
  function automatic int pair_count(input int depth);
    return (depth + 1) / 2;
  endfunction

endpackage

// File: rtl/weight_fetch_ctrl_valid_pipe.sv
// Fixed-latency token delay line, matching issued tokens to memory read data.
module valid_pipe
  import cnn_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic clk_i,
  input  logic clr_i,
  input  tok_t tok_i,
  output tok_t tok_o
);

  tok_t [LAT-1:0] stg_q;

  // shift one stage per cycle; clear drops every token in flight
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      stg_q <= '0;
    end else begin
      stg_q[0] <= tok_i;
      for (int i = 1; i < LAT; i++) stg_q[i] <= stg_q[i-1];
    end
  end

  assign tok_o = stg_q[LAT-1];

endmodule

// File: rtl/weight_fetch_ctrl.sv
// Weight memory sweep sequencer: issues two rows per cycle and drives the
// accumulator controls in step with the memory read latency.
module weight_fetch_ctrl
  import cnn_pkg::*;
#(
  parameter int DEPTH   = FC_DEPTH,
  parameter int ADDR_W  = FC_ADDR_W,
  parameter int MEM_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              hold_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] addr1_o,
  output logic [ADDR_W-1:0] addr2_o,
  output logic              acc_clr_o,
  output logic              acc_en_o,
  output logic              valid1_o,
  output logic              valid2_o,
  output logic              last_o
);

  localparam int                PAIRS  = pair_count(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_K = ADDR_W'(PAIRS - 1);
  localparam bit                ODD    = (DEPTH % 2) != 0;

  fsm_state_e        state_q, state_d;
  logic [ADDR_W-1:0] k_q, k_d;
  logic [ADDR_W-1:0] addr1_q, addr1_d, addr2_q, addr2_d;
  logic              busy_q, busy_d, done_q, done_d, clr_q, clr_d;
  tok_t              tok_q, tok_d, pipe_tok;
  logic              issue, final_pair;

  // hold only matters while sweeping; elsewhere it is ignored
  assign issue      = (state_q == RUN) && !hold_i;
  assign final_pair = (k_q == LAST_K);

  // state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // next-state: drain ends on the edge the final token leaves the pipe
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_d = CLR;
      CLR:     state_d = RUN;
      RUN:     if (issue && final_pair) state_d = DRAIN;
      DRAIN:   if (pipe_tok.lst) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // outputs and issue datapath, registered below so no input reaches a port combinationally
  always_comb begin
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
    clr_d   = (state_q == CLR);
    k_d     = k_q;
    addr1_d = addr1_q;
    addr2_d = addr2_q;
    tok_d   = '0;  // bubble unless a pair issues
    if (state_q == CLR) k_d = '0;
    if (issue) begin
      k_d     = k_q + 1'b1;
      addr1_d = k_q << 1;
      // odd depth: the final pair re-reads the even row so port 2 stays in range
      addr2_d = (ODD && final_pair) ? (k_q << 1) : ((k_q << 1) | ADDR_W'(1));
      tok_d   = '{v1: 1'b1, v2: !(ODD && final_pair), lst: final_pair};
    end else if (state_d == IDLE) begin
      addr1_d = '0;
      addr2_d = '0;
    end
  end

  // registered outputs and issue stage
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      k_q     <= '0;
      addr1_q <= '0;
      addr2_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      clr_q   <= 1'b0;
      tok_q   <= '0;
    end else begin
      k_q     <= k_d;
      addr1_q <= addr1_d;
      addr2_q <= addr2_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      clr_q   <= clr_d;
      tok_q   <= tok_d;
    end
  end

  valid_pipe #(.LAT(MEM_LAT)) u_pipe (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .tok_i (tok_q),
    .tok_o (pipe_tok)
  );

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign acc_clr_o = clr_q;
  assign addr1_o   = addr1_q;
  assign addr2_o   = addr2_q;
  assign acc_en_o  = pipe_tok.v1;
  assign valid1_o  = pipe_tok.v1;
  assign valid2_o  = pipe_tok.v2;
  assign last_o    = pipe_tok.lst;

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Bench for weight_fetch_ctrl: three configurations driven one at a time,
// checked every cycle against an event-schedule model of the sweep.
module tb_weight_fetch_ctrl;

  localparam int NI       = 3;
  localparam int DEP [NI] = '{784, 7, 16};
  localparam int LAT [NI] = '{1, 2, 3};
  localparam int HMAX     = 2048;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0] rst_v, start_v, hold_v;
  logic [NI-1:0] busy_v, done_v, clr_v, en_v, v1_v, v2_v, last_v;
  logic [9:0]    a1_0, a2_0;
  logic [2:0]    a1_1, a2_1;
  logic [3:0]    a1_2, a2_2;

  weight_fetch_ctrl #(.DEPTH(784), .ADDR_W(10), .MEM_LAT(1)) u_d0 (
    .clk_i(clk), .rst_i(rst_v[0]), .start_i(start_v[0]), .hold_i(hold_v[0]),
    .busy_o(busy_v[0]), .done_o(done_v[0]), .addr1_o(a1_0), .addr2_o(a2_0),
    .acc_clr_o(clr_v[0]), .acc_en_o(en_v[0]), .valid1_o(v1_v[0]),
    .valid2_o(v2_v[0]), .last_o(last_v[0]));

  weight_fetch_ctrl #(.DEPTH(7), .ADDR_W(3), .MEM_LAT(2)) u_d1 (
    .clk_i(clk), .rst_i(rst_v[1]), .start_i(start_v[1]), .hold_i(hold_v[1]),
    .busy_o(busy_v[1]), .done_o(done_v[1]), .addr1_o(a1_1), .addr2_o(a2_1),
    .acc_clr_o(clr_v[1]), .acc_en_o(en_v[1]), .valid1_o(v1_v[1]),
    .valid2_o(v2_v[1]), .last_o(last_v[1]));

  weight_fetch_ctrl #(.DEPTH(16), .ADDR_W(4), .MEM_LAT(3)) u_d2 (
    .clk_i(clk), .rst_i(rst_v[2]), .start_i(start_v[2]), .hold_i(hold_v[2]),
    .busy_o(busy_v[2]), .done_o(done_v[2]), .addr1_o(a1_2), .addr2_o(a2_2),
    .acc_clr_o(clr_v[2]), .acc_en_o(en_v[2]), .valid1_o(v1_v[2]),
    .valid2_o(v2_v[2]), .last_o(last_v[2]));

  int n_tests = 0;
  int n_fail  = 0;

  // expected accumulator schedule, indexed by cycle relative to the start edge
  bit         ex_en   [HMAX];
  bit         ex_v2   [HMAX];
  bit         ex_last [HMAX];
  int         ex_pair [HMAX];
  logic [9:0] h1 [HMAX];
  logic [9:0] h2 [HMAX];

  function automatic logic [9:0] get_a1(input int id);
    case (id)
      0:       return a1_0;
      1:       return {7'd0, a1_1};
      default: return {6'd0, a1_2};
    endcase
  endfunction

  function automatic logic [9:0] get_a2(input int id);
    case (id)
      0:       return a2_0;
      1:       return {7'd0, a2_1};
      default: return {6'd0, a2_2};
    endcase
  endfunction

  // {busy, done, acc_clr, acc_en, valid1, valid2, last}
  function automatic logic [6:0] ctl(input int id);
    return {busy_v[id], done_v[id], clr_v[id], en_v[id], v1_v[id], v2_v[id], last_v[id]};
  endfunction

  task automatic chk(input string tag, input int id, input int rel,
                     input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s dut%0d rel %0d: observed %0h expected %0h", tag, id, rel, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // hold_mode: 0 none, 1 random 30%, 2 three cycles after pair 4
  // poke: pulse start mid-RUN and during DONE; rst_at: reset when that many pairs issued
  task automatic run_sweep(input int id, input int hold_mode, input bit poke, input int rst_at);
    int         p, lat, issued, done_rel, rel, r, hold_used, n_en;
    bit         odd, hn, poked, exp_busy;
    logic [9:0] e1, e2, pa1, pa2;
    logic [6:0] ex_ctl;
    p         = (DEP[id] + 1) / 2;
    lat       = LAT[id];
    odd       = (DEP[id] % 2) != 0;
    issued    = 0;
    done_rel  = -1;
    hold_used = 0;
    n_en      = 0;
    poked     = 1'b0;
    e1        = '0;
    e2        = '0;
    for (int i = 0; i < HMAX; i++) ex_en[i] = 1'b0;

    start_v[id] = 1'b1;
    step();
    start_v[id] = 1'b0;
    rel = 0;
    chk("ctl_t0", id, rel, ctl(id), 7'b1000000);
    chk("addr_t0", id, rel, {get_a1(id), get_a2(id)}, 20'd0);
    h1[0] = get_a1(id);
    h2[0] = get_a2(id);

    while (1) begin
      r = rel + 1;
      case (hold_mode)
        1:       hn = ($urandom_range(99) < 30);
        2:       hn = (issued == 4) && (hold_used < 3) && (r >= 2);
        default: hn = 1'b0;
      endcase
      if (hn && hold_mode == 2) hold_used++;
      hold_v[id]  = hn;
      start_v[id] = 1'b0;
      if (poke && !poked && issued == 2) begin
        start_v[id] = 1'b1;
        poked = 1'b1;
      end
      if (poke && rel == done_rel) start_v[id] = 1'b1;

      if (rst_at >= 0 && issued == rst_at) begin
        rst_v[id] = 1'b1;
        step();
        rst_v[id]   = 1'b0;
        hold_v[id]  = 1'b0;
        start_v[id] = 1'b0;
        chk("ctl_rst", id, r, ctl(id), 7'd0);
        chk("addr_rst", id, r, {get_a1(id), get_a2(id)}, 20'd0);
        for (int i = 0; i < lat + 4; i++) begin
          step();
          chk("ctl_after_rst", id, r + 1 + i, ctl(id), 7'd0);
        end
        return;
      end

      // a pair issues on every RUN edge without hold, starting two edges after start
      if (r >= 2 && issued < p && !hn) begin
        e1 = 10'(2 * issued);
        e2 = (odd && issued == p - 1) ? e1 : e1 + 10'd1;
        ex_en[r+lat]   = 1'b1;
        ex_v2[r+lat]   = !(odd && issued == p - 1);
        ex_last[r+lat] = (issued == p - 1);
        ex_pair[r+lat] = issued;
        issued++;
        if (issued == p) done_rel = r + lat + 1;
      end

      step();
      rel = r;
      if (done_rel >= 0 && rel > done_rel) begin
        e1 = '0;
        e2 = '0;
      end
      exp_busy = (done_rel < 0) || (rel <= done_rel);
      ex_ctl = {exp_busy, rel == done_rel, rel == 1, ex_en[rel], ex_en[rel],
                ex_en[rel] & ex_v2[rel], ex_en[rel] & ex_last[rel]};
      chk("ctl", id, rel, ctl(id), ex_ctl);
      chk("addr", id, rel, {get_a1(id), get_a2(id)}, {e1, e2});
      h1[rel] = get_a1(id);
      h2[rel] = get_a2(id);
      if (en_v[id]) n_en++;

      // memory view: data arriving now was addressed lat cycles ago
      if (ex_en[rel]) begin
        pa1 = 10'(2 * ex_pair[rel]);
        pa2 = (odd && ex_pair[rel] == p - 1) ? pa1 : pa1 + 10'd1;
        chk("mem_pair", id, rel, {h1[rel-lat], h2[rel-lat]}, {pa1, pa2});
      end

      if (done_rel >= 0 && rel == done_rel + 1) break;
      if (rel >= HMAX - 8) begin
        n_tests++;
        n_fail++;
        $error("FAIL timeout dut%0d: no done after %0d cycles, expected by %0d", id, rel, done_rel);
        break;
      end
    end
    hold_v[id]  = 1'b0;
    start_v[id] = 1'b0;
    chk("acc_count", id, rel, n_en, p);
  endtask

  initial begin
    // start alongside reset must be dropped
    rst_v   = '1;
    start_v = '1;
    hold_v  = '1;
    repeat (3) step();
    for (int i = 0; i < NI; i++) begin
      chk("rst_ctl", i, 0, ctl(i), 7'd0);
      chk("rst_addr", i, 0, {get_a1(i), get_a2(i)}, 20'd0);
    end
    rst_v   = '0;
    start_v = '0;
    hold_v  = '0;
    step();
    for (int i = 0; i < NI; i++) chk("idle_ctl", i, 1, ctl(i), 7'd0);

    run_sweep(0, 0, 1'b0, -1);   // full 784-row sweep
    run_sweep(0, 0, 1'b1, -1);   // back-to-back, stray starts ignored
    run_sweep(1, 0, 1'b0, -1);   // odd depth, latency 2
    run_sweep(1, 1, 1'b1, -1);
    run_sweep(2, 2, 1'b0, -1);   // three-cycle hold mid-run
    run_sweep(2, 1, 1'b0, -1);
    run_sweep(0, 1, 1'b0, 100);  // reset at pair 100
    run_sweep(0, 1, 1'b0, -1);   // restart after reset

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
